alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execution unit for the pipelined CPU: takes one decoded ALU operation per handshake, computes the result and the cf/zf/nf flags, and returns them with the destination register tag through a registered output. It is the WIDTH-generic successor of the fixed 16-bit single-cycle ALU path. It adds valid/ready flow control, carry-chained ADC/SBC, CMP without write-back, and an iterative multi-cycle multiplier.

## Interface
- WIDTH, 16: datapath width; power of two, ≥ 4; shift amount field SW = log2(WIDTH)
- TAG_W, 3: destination tag width (gr index)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- enable  in  1  global advance; 0 freezes all state, no handshake completes
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  4  opcode (see Operation)
- in_a, in_b  in  WIDTH  operands
- in_cf  in  1  carry/borrow in for ADC/SBC
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag of result
- out_wb  out  1  write result to register file
- out_cf, out_zf, out_nf  out  1 each  flags
- out_err  out  1  illegal opcode
- busy  out  1  multiply in progress

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 ADC (a+b+in_cf), 5 SUB, 6 SBC (a−b−in_cf), 7 CMP (a−b, out_wb=0).
  - 8 SLL, 9 SRL, 10 SRA; shift amount = in_b[SW-1:0].
  - 11 MUL (low WIDTH bits, unsigned), 12 MULH (high WIDTH bits, unsigned), 13 PASSB.
  - 14–15 illegal: result 0, out_wb=0, out_err=1, flags 0.
- cf rules:
  - ADD/ADC: carry out.
  - SUB/SBC/CMP: borrow out (1 when a < b + borrow-in, unsigned).
  - Shifts: last bit shifted out; 0 for shift amount 0.
  - MUL: 1 if the high half is nonzero.
  - Logic/PASSB/MULH: 0.
- zf = (result == 0). For CMP the result is the difference. nf = result[WIDTH-1].
- out_wb = 1 for all legal ops except CMP.
- FSM states:
  - IDLE: accept; single-cycle ops load the output register directly.
  - MUL: shift-add, one iteration per enabled cycle, WIDTH iterations; on the last iteration load the output register and return to IDLE.
- in_ready = enable && reset && state==IDLE && (!out_valid || out_ready).
- Output register is held stable while out_valid && !out_ready.
- enable=0: counter, operands, output register and out_valid are all frozen; in_ready=0; out_ready is ignored.
- Reset: all outputs 0, state IDLE, any multiply in flight is aborted.

## Timing
- Accept on edge k (in_valid && in_ready). A single-cycle op has out_valid=1 and the result from after edge k (latency 1).
- MUL/MULH: busy=1 after edge k through edge k+WIDTH−1; out_valid=1 after edge k+WIDTH; in_ready=0 throughout.
- Throughput: one single-cycle op per cycle while out_ready=1. Output consumption and a new acceptance may occur on the same edge.
- out_valid drops on a consumption edge with no simultaneous acceptance.
- Stall: if out_valid && !out_ready, then in_ready=0. A finished multiply waits in the MUL last-iteration hold, busy=1, until the output register is free.
- Async reset takes effect immediately, without waiting for a clock edge. The first acceptance is possible on the first enabled edge after release.

## Test plan
- Reset low, then release with enable=1 → all outputs 0 during reset; in_ready=1 after release. Then AND 0x0012,0x0012 tag 3 → 0x0012, tag 3, zf=0, cf=0, out_wb=1, one cycle later.
- ADD 0xFFFF+0x0001 → 0x0000, cf=1, zf=1. ADC 0x0001+0x0001 with in_cf=1 → 0x0003. SUB 0x0003−0x0005 → 0xFFFE, cf=1, nf=1. CMP 5,5 → zf=1, out_wb=0.
- SRA 0x8001 by 3 → 0xF000, cf=0. SLL 0x8001 by 1 → 0x0002, cf=1. Opcode 15 → out_err=1, out_wb=0.
- MUL 0x0100×0x0100 → 0x0000, cf=1; MULH of the same → 0x0001. out_valid exactly 16 cycles after accept; busy and in_ready=0 meanwhile.
- Back-to-back stream of 4 ORs with out_ready toggled 1,0,0,1 → no result lost or duplicated; output stable while stalled.
- Reset asserted mid-MUL, and separately enable=0 for 5 cycles mid-MUL → abort with outputs 0 in the first case; correct result delivered 5 cycles late in the second.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execution unit for the pipelined CPU. It accepts one decoded ALU operation
// per valid/ready handshake. It returns the result, the cf/zf/nf flags and
// the destination tag through a registered output.
// Single-cycle ops load the output register on the accept edge. MUL/MULH run
// an iterative shift-add multiplier for WIDTH enabled cycles.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   enable            global advance; 0 freezes every register
//   in_valid/in_ready operation handshake (in_op, in_a, in_b, in_cf, in_tag)
//   out_valid/out_ready result handshake
//   out_result, out_tag, out_wb, out_cf, out_zf, out_nf, out_err
//   busy              multiply in progress
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cf,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_wb,
    output logic             out_cf,
    output logic             out_zf,
    output logic             out_nf,
    output logic             out_err,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_XOR  = 4'd2,
                           OP_ADD = 4'd3,  OP_ADC = 4'd4,  OP_SUB  = 4'd5,
                           OP_SBC = 4'd6,  OP_CMP = 4'd7,  OP_SLL  = 4'd8,
                           OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_MUL  = 4'd11,
                           OP_MULH = 4'd12, OP_PASSB = 4'd13;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [SW-1:0]    mul_cnt;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_high;
    logic [TAG_W-1:0] mul_tag;

    logic out_free;
    logic accept;
    logic is_mul;

    assign out_free = !out_valid || out_ready;
    assign in_ready = enable && reset && (state == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (in_op == OP_MUL) || (in_op == OP_MULH);
    assign busy     = (state == S_MUL);

    // Single-cycle datapath. The extra MSB of the add/sub vectors holds
    // carry/borrow. The shift vectors carry one extra bit on the side that
    // bits leave, so that bit is the last bit shifted out. With a shift
    // amount of 0 that extra bit stays 0.
    logic [SW-1:0]  shamt;
    logic           cin;
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic [WIDTH:0] sll_w;
    logic [WIDTH:0] srl_w;
    logic [WIDTH:0] sra_w;

    assign shamt = in_b[SW-1:0];
    assign cin   = ((in_op == OP_ADC) || (in_op == OP_SBC)) ? in_cf : 1'b0;
    assign add_w = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cin};
    assign sub_w = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, cin};
    assign sll_w = {1'b0, in_a} << shamt;
    assign srl_w = {in_a, 1'b0} >> shamt;
    assign sra_w = $signed({in_a, 1'b0}) >>> shamt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cf;
    logic             alu_wb;
    logic             alu_err;

    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_wb  = 1'b1;
        alu_err = 1'b0;
        case (in_op)
            OP_AND:   alu_res = in_a & in_b;
            OP_OR:    alu_res = in_a | in_b;
            OP_XOR:   alu_res = in_a ^ in_b;
            OP_ADD, OP_ADC: begin
                alu_res = add_w[WIDTH-1:0];
                alu_cf  = add_w[WIDTH];
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_cf  = sub_w[WIDTH];
                alu_wb  = (in_op != OP_CMP);
            end
            OP_SLL: begin
                alu_res = sll_w[WIDTH-1:0];
                alu_cf  = sll_w[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_w[WIDTH:1];
                alu_cf  = srl_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[WIDTH:1];
                alu_cf  = sra_w[0];
            end
            OP_PASSB: alu_res = in_b;
            default: begin
                alu_wb  = 1'b0;
                alu_err = 1'b1;
            end
        endcase
    end

    // One shift-add step: {mul_hi, mul_lo} starts as {0, b} and after WIDTH
    // steps holds the full 2*WIDTH-bit product a*b.
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             mul_last;
    logic             mul_finish;

    assign step_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : '0);
    assign step_hi    = step_sum[WIDTH:1];
    assign step_lo    = {step_sum[0], mul_lo[WIDTH-1:1]};
    assign mul_last   = (mul_cnt == SW'(WIDTH - 1));
    // The last step is withheld until the output register can take it.
    assign mul_finish = (state == S_MUL) && mul_last && out_free;

    // Value loaded into the output register. No accept can happen in S_MUL,
    // so the state selects the source.
    logic             ld;
    logic [WIDTH-1:0] ld_res;
    logic             ld_cf;
    logic             ld_wb;
    logic             ld_err;

    assign ld     = (accept && !is_mul) || mul_finish;
    assign ld_res = (state == S_MUL) ? (mul_high ? step_hi : step_lo) : alu_res;
    assign ld_cf  = (state == S_MUL) ? (!mul_high && (step_hi != '0)) : alu_cf;
    assign ld_wb  = (state == S_MUL) ? 1'b1 : alu_wb;
    assign ld_err = (state == S_MUL) ? 1'b0 : alu_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            mul_cnt    <= '0;
            mul_a      <= '0;
            mul_hi     <= '0;
            mul_lo     <= '0;
            mul_high   <= 1'b0;
            mul_tag    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_wb     <= 1'b0;
            out_cf     <= 1'b0;
            out_zf     <= 1'b0;
            out_nf     <= 1'b0;
            out_err    <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        state    <= S_MUL;
                        mul_cnt  <= '0;
                        mul_a    <= in_a;
                        mul_hi   <= '0;
                        mul_lo   <= in_b;
                        mul_high <= (in_op == OP_MULH);
                        mul_tag  <= in_tag;
                    end
                end
                S_MUL: begin
                    if (!mul_last) begin
                        mul_cnt <= mul_cnt + SW'(1);
                        mul_hi  <= step_hi;
                        mul_lo  <= step_lo;
                    end else if (out_free) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (ld) begin
                out_valid  <= 1'b1;
                out_result <= ld_res;
                out_tag    <= (state == S_MUL) ? mul_tag : in_tag;
                out_wb     <= ld_wb;
                out_cf     <= ld_err ? 1'b0 : ld_cf;
                out_zf     <= ld_err ? 1'b0 : (ld_res == '0);
                out_nf     <= ld_err ? 1'b0 : ld_res[WIDTH-1];
                out_err    <= ld_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit (WIDTH=16, TAG_W=3). A scoreboard queue gets
// the expected result at each accept. A monitor pops and compares it when
// the DUT hands the result over.
module tb_alu_exec_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cf = 1'b0;
    logic [2:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [2:0]  out_tag;
    logic        out_wb, out_cf, out_zf, out_nf, out_err, busy;

    alu_exec_unit #(.WIDTH(16), .TAG_W(3)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cf(in_cf), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_wb(out_wb),
        .out_cf(out_cf), .out_zf(out_zf), .out_nf(out_nf),
        .out_err(out_err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  tag;
        logic        wb, cf, zf, nf, err;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference model written from the opcode table with plain integer math.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic ci,
                                   input logic [2:0] tag);
        exp_t        e;
        logic [31:0] w;
        int          sh;
        sh    = int'(b[3:0]);
        e     = '0;
        e.tag = tag;
        e.wb  = 1'b1;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a ^ b;
            4'd3:  begin w = 32'(a) + 32'(b); e.res = w[15:0]; e.cf = w[16]; end
            4'd4:  begin w = 32'(a) + 32'(b) + 32'(ci); e.res = w[15:0]; e.cf = w[16]; end
            4'd5, 4'd7: begin
                e.res = a - b;
                e.cf  = (int'(a) < int'(b));
                e.wb  = (op != 4'd7);
            end
            4'd6:  begin e.res = a - b - 16'(ci); e.cf = (int'(a) < int'(b) + int'(ci)); end
            4'd8:  begin e.res = a << sh; e.cf = (sh == 0) ? 1'b0 : a[16 - sh]; end
            4'd9:  begin e.res = a >> sh; e.cf = (sh == 0) ? 1'b0 : a[sh - 1]; end
            4'd10: begin e.res = $signed(a) >>> sh; e.cf = (sh == 0) ? 1'b0 : a[sh - 1]; end
            4'd11: begin w = 32'(a) * 32'(b); e.res = w[15:0]; e.cf = (w[31:16] != 16'h0); end
            4'd12: begin w = 32'(a) * 32'(b); e.res = w[31:16]; end
            4'd13: e.res = b;
            default: begin e.res = '0; e.wb = 1'b0; e.err = 1'b1; end
        endcase
        if (!e.err) begin
            e.zf = (e.res == 16'h0);
            e.nf = e.res[15];
        end
        return e;
    endfunction

    // Monitor: compares on each consuming cycle and checks that a stalled
    // output holds still. It samples 2 time units after the falling edge,
    // once stimulus driven on that edge has settled.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res = '0;
    exp_t        obs_now;
    assign obs_now = {out_result, out_tag, out_wb, out_cf, out_zf, out_nf, out_err};

    always @(negedge clock) begin
        #2;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 64'({out_valid, out_result}), 64'({1'b1, prev_res}));
            if (enable && out_valid && out_ready) begin
                n_assert++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed result %h tag %0d, expected none", out_result, out_tag);
                end
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn tag=%0d result=%h cf=%b zf=%b nf=%b wb=%b err=%b (exp %h)",
                             out_tag, out_result, out_cf, out_zf, out_nf, out_wb, out_err, e.res);
                    chk("result", 64'(obs_now), 64'(e));
                end
            end
            prev_stall = out_valid && !(out_ready && enable);
            prev_res   = out_result;
        end
    end

    // Offer one operation starting at a falling edge; returns at the falling
    // edge that follows the accepting rising edge.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [2:0] tag);
        int   tries;
        logic acc;
        tries = 0;
        acc   = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cf = ci; in_tag = tag;
        while (!acc && tries < 100) begin
            #1;
            acc = in_ready;
            @(posedge clock);
            if (acc) sb.push_back(model(op, a, b, ci, tag));
            @(negedge clock);
            tries++;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int   cyc;
        int   sent;
        logic acc;
        logic [3:0] pat;

        // Reset and release.
        enable = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_outputs", 64'({out_valid, out_result, out_tag, out_wb, out_cf, out_zf,
                                  out_nf, out_err, busy, in_ready}), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'(1));
        @(negedge clock);

        // Directed single-cycle ops, issued back to back.
        send(4'd0, 16'h0012, 16'h0012, 1'b0, 3'd3);
        chk("and_latency", 64'({out_valid, out_result, out_tag}), 64'({1'b1, 16'h0012, 3'd3}));
        send(4'd3, 16'hFFFF, 16'h0001, 1'b0, 3'd1);
        send(4'd4, 16'h0001, 16'h0001, 1'b1, 3'd2);
        send(4'd5, 16'h0003, 16'h0005, 1'b0, 3'd4);
        send(4'd7, 16'h0005, 16'h0005, 1'b0, 3'd5);
        send(4'd6, 16'h0010, 16'h0010, 1'b1, 3'd6);
        send(4'd10, 16'h8001, 16'h0003, 1'b0, 3'd7);
        send(4'd8, 16'h8001, 16'h0001, 1'b0, 3'd0);
        send(4'd9, 16'h00F4, 16'h0003, 1'b0, 3'd1);
        send(4'd8, 16'h1234, 16'h0000, 1'b0, 3'd2);
        send(4'd2, 16'hA5A5, 16'h5A5A, 1'b0, 3'd3);
        send(4'd13, 16'h0000, 16'hBEEF, 1'b0, 3'd4);
        send(4'd15, 16'h1234, 16'h5678, 1'b0, 3'd5);
        send(4'd14, 16'h0000, 16'h0000, 1'b0, 3'd6);
        drain();

        // MUL timing: busy and not ready for WIDTH cycles, result after WIDTH edges.
        send(4'd11, 16'h0100, 16'h0100, 1'b0, 3'd2);
        for (int j = 0; j < 16; j++) begin
            chk("mul_busy", 64'({busy, in_ready, out_valid}), 64'(3'b100));
            @(negedge clock);
        end
        chk("mul_done", 64'({busy, out_valid}), 64'(2'b01));
        send(4'd12, 16'h0100, 16'h0100, 1'b0, 3'd3);
        drain();
        send(4'd12, 16'hFFFF, 16'hFFFF, 1'b0, 3'd4);
        send(4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 3'd5);
        drain();

        // Stream of four ORs with out_ready following 1,0,0,1.
        pat  = 4'b1001;
        sent = 0;
        cyc  = 0;
        while ((sent < 4 || sb.size() > 0) && cyc < 60) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 4);
            in_op     = 4'd1;
            in_a      = 16'h0101 << sent;
            in_b      = 16'h1000 + 16'(sent);
            in_tag    = 3'(sent);
            in_cf     = 1'b0;
            #1;
            acc = in_valid && in_ready;
            @(posedge clock);
            if (acc) begin
                sb.push_back(model(4'd1, in_a, in_b, 1'b0, in_tag));
                sent++;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 64'(4));
        drain();

        // enable=0 for 5 cycles in the middle of a multiply.
        send(4'd11, 16'h1234, 16'h0005, 1'b0, 3'd5);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (cyc == 3) enable = 1'b0;
            if (cyc == 8) enable = 1'b1;
            #1;
            if (!enable) chk("freeze_busy", 64'({busy, in_ready, out_valid}), 64'(3'b100));
            @(negedge clock);
            cyc++;
        end
        chk("freeze_latency", 64'(cyc), 64'(21));
        drain();

        // Reset in the middle of a multiply aborts it.
        send(4'd12, 16'hFFFF, 16'hFFFF, 1'b0, 3'd6);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_outputs", 64'({out_valid, out_result, out_tag, out_wb, out_cf, out_zf,
                                  out_nf, out_err, busy, in_ready}), 64'(0));
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready_after_abort", 64'(in_ready), 64'(1));
        @(negedge clock);
        repeat (20) @(negedge clock);
        send(4'd3, 16'h7FFF, 16'h0001, 1'b0, 3'd7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
